// File: rtl/cpu_cen_gen.sv
// T80 clock-enable generator: T-state pulses from the master clock, with ULA contention stretching and
// bus-idle-gated turbo switching. Optional build macro: TURBO_IO_SLOWDOWN_EN (I/O cycles forced to base speed).
module cpu_cen_gen #(
  parameter int BASE_DIV = 8,
  parameter int CNT_W    = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] turbo_req,
  input  logic       contend,
  input  logic       mreq_n,
  input  logic       iorq_n,
  input  logic       m1_n,
  output logic       cpu_cen,
  output logic       cpu_cen_n,
  output logic [1:0] turbo_cur,
  output logic       turbo_busy
);

  localparam int PW = CNT_W + 1;
  localparam logic [PW-1:0] ONE_P  = PW'(1);
  localparam logic [PW-1:0] BASE_P = PW'(BASE_DIV);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_turbo_cur;
  logic             r_cen;
  logic             r_cen_n;
  logic             r_busy;

  logic [PW-1:0]    w_period;
  logic [PW-1:0]    w_pm1;
  logic [PW-1:0]    w_hm1;
  logic [PW-1:0]    w_cnt_ext;
  logic             w_edge;
  logic             w_stall;
  logic             w_fire;
  logic             w_half_hit;
  logic             w_apply;

`ifdef TURBO_IO_SLOWDOWN_EN
  // Select the T-state length; a non-M1 I/O cycle runs at base speed without touching turbo_cur.
  always_comb begin
    w_period = BASE_P >> r_turbo_cur;
    if (!iorq_n && m1_n) begin
      w_period = BASE_P;
    end else begin
      w_period = BASE_P >> r_turbo_cur;
    end
  end
`else
  logic w_unused_m1;
  assign w_unused_m1 = m1_n;

  // Select the T-state length from the speed in effect.
  always_comb begin
    w_period = BASE_P >> r_turbo_cur;
  end
`endif

  // Edge detection; >= lets a counter left beyond a shrunken period wrap immediately.
  always_comb begin
    w_pm1      = w_period - ONE_P;
    w_hm1      = (w_period >> 1) - ONE_P;
    w_cnt_ext  = {1'b0, r_cnt};
    w_edge     = (w_cnt_ext >= w_pm1);
    w_stall    = w_edge && contend && (r_turbo_cur == 2'd0);
    w_fire     = w_edge && !w_stall;
    w_half_hit = 1'b0;
    if (w_period == ONE_P) begin
      w_half_hit = w_fire;
    end else begin
      w_half_hit = (w_cnt_ext == w_hm1);
    end
    w_apply = (r_state == ST_PEND) && (turbo_req != r_turbo_cur) && w_fire && mreq_n && iorq_n;
  end

  // Phase counter and registered enable pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= {CNT_W{1'b0}};
      r_cen   <= 1'b0;
      r_cen_n <= 1'b0;
    end else begin
      r_cen   <= w_fire;
      r_cen_n <= w_half_hit;
      if (w_fire) begin
        r_cnt <= {CNT_W{1'b0}};
      end else if (w_stall) begin
        r_cnt <= w_pm1[CNT_W-1:0];
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  // Turbo FSM: a change lands only on a fired edge with the bus idle, so no bus cycle is cut short.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_turbo_cur <= 2'd0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (turbo_req != r_turbo_cur) begin
            r_state <= ST_PEND;
            r_busy  <= 1'b1;
          end else begin
            r_busy  <= 1'b0;
          end
        end
        ST_PEND: begin
          if (turbo_req == r_turbo_cur) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else if (w_apply) begin
            r_turbo_cur <= turbo_req;
            r_state     <= ST_IDLE;
            r_busy      <= 1'b0;
          end else begin
            r_busy <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign cpu_cen    = r_cen;
  assign cpu_cen_n  = r_cen_n;
  assign turbo_cur  = r_turbo_cur;
  assign turbo_busy = r_busy;

endmodule

// File: tb/tb_cpu_cen_gen.sv
// Directed self-checking bench for cpu_cen_gen: T-state timing, contention, turbo switching and reset.
module tb_cpu_cen_gen;

  logic       clk;
  logic       rst;
  logic [1:0] turbo_req;
  logic       contend;
  logic       mreq_n;
  logic       iorq_n;
  logic       m1_n;
  logic       cpu_cen;
  logic       cpu_cen_n;
  logic [1:0] turbo_cur;
  logic       turbo_busy;

  int cyc = 0;
  int errors = 0;
  int checks = 0;

  cpu_cen_gen #(.BASE_DIV(8), .CNT_W(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .turbo_req  (turbo_req),
    .contend    (contend),
    .mreq_n     (mreq_n),
    .iorq_n     (iorq_n),
    .m1_n       (m1_n),
    .cpu_cen    (cpu_cen),
    .cpu_cen_n  (cpu_cen_n),
    .turbo_cur  (turbo_cur),
    .turbo_busy (turbo_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for the next cpu_cen; returns its cycle and the cycle of the preceding cpu_cen_n.
  task automatic wait_cen(input int max_clk, output int at_cyc, output int n_cyc);
    at_cyc = -1000;
    n_cyc  = -1000;
    for (int k = 0; k < max_clk; k++) begin
      @(negedge clk);
      if (cpu_cen_n && !cpu_cen && n_cyc < 0) n_cyc = cyc;
      if (cpu_cen) begin
        at_cyc = cyc;
        break;
      end
    end
  endtask

  initial begin
    int c0, c1, c2, c3, c4, c5, c6, c7, n;
    rst = 1'b1; turbo_req = 2'd0; contend = 1'b0;
    mreq_n = 1'b1; iorq_n = 1'b1; m1_n = 1'b1;

    // Reset held for three clocks
    repeat (3) @(negedge clk);
    chk("rst_cen", int'(cpu_cen), 0);
    chk("rst_cen_n", int'(cpu_cen_n), 0);
    chk("rst_turbo_cur", int'(turbo_cur), 0);
    chk("rst_busy", int'(turbo_busy), 0);
    rst = 1'b0;
    c0 = cyc;

    // Base rate: 8-clk T-states, cpu_cen_n 4 clk ahead
    wait_cen(20, c1, n);
    chk("t1_first_cen", c1 - c0, 8);
    chk("t1_first_cen_n", c1 - n, 4);
    wait_cen(20, c2, n);
    chk("t1_period", c2 - c1, 8);
    chk("t1_cen_n", c2 - n, 4);

    // Contention high for 5 clk across the edge stretches the T-state to 13
    fork
      wait_cen(30, c3, n);
      begin
        repeat (7) @(negedge clk);
        contend = 1'b1;
        repeat (5) @(negedge clk);
        contend = 1'b0;
      end
    join
    chk("t2_stretched", c3 - c2, 13);
    wait_cen(20, c4, n);
    chk("t2_after", c4 - c3, 8);

    // Turbo request while the bus is busy stays pending
    mreq_n = 1'b0; turbo_req = 2'd2;
    @(negedge clk);
    chk("t3_busy_set", int'(turbo_busy), 1);
    chk("t3_cur_hold", int'(turbo_cur), 0);
    wait_cen(20, c5, n);
    chk("t3_period_hold", c5 - c4, 8);
    chk("t3_cur_still0", int'(turbo_cur), 0);
    chk("t3_busy_still", int'(turbo_busy), 1);
    mreq_n = 1'b1;
    wait_cen(20, c6, n);
    chk("t3_apply_period", c6 - c5, 8);
    chk("t3_cur_applied", int'(turbo_cur), 2);
    chk("t3_busy_clear", int'(turbo_busy), 0);
    wait_cen(10, c7, n);
    chk("t3_fast_period", c7 - c6, 2);
    chk("t3_fast_cen_n", n - c6, 1);
    wait_cen(10, c1, n);
    chk("t3_fast_period2", c1 - c7, 2);

    // Turbo 3: enables every clock, contention ignored
    turbo_req = 2'd3;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (turbo_cur == 2'd3) break;
    end
    chk("t4_cur", int'(turbo_cur), 3);
    contend = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t4_cen", int'(cpu_cen), 1);
      chk("t4_cen_n", int'(cpu_cen_n), 1);
    end
    contend = 1'b0;
    chk("t4_busy", int'(turbo_busy), 0);

    // Reset mid T-state at turbo 1 with cnt=2
    turbo_req = 2'd1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (turbo_cur == 2'd1) break;
    end
    chk("t5_cur1", int'(turbo_cur), 1);
    repeat (2) @(negedge clk);
    rst = 1'b1; turbo_req = 2'd0;
    @(negedge clk);
    chk("t5_rst_cen", int'(cpu_cen), 0);
    chk("t5_rst_cen_n", int'(cpu_cen_n), 0);
    chk("t5_rst_cur", int'(turbo_cur), 0);
    chk("t5_rst_busy", int'(turbo_busy), 0);
    rst = 1'b0;
    c0 = cyc;
    wait_cen(20, c1, n);
    chk("t5_first_cen", c1 - c0, 8);

`ifdef TURBO_IO_SLOWDOWN_EN
    // I/O cycles forced to base speed at turbo 2
    turbo_req = 2'd2;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (turbo_cur == 2'd2) break;
    end
    wait_cen(10, c2, n);
    iorq_n = 1'b0; m1_n = 1'b1;
    wait_cen(20, c3, n);
    chk("t6_io_period", c3 - c2, 8);
    chk("t6_io_cur", int'(turbo_cur), 2);
    wait_cen(20, c4, n);
    chk("t6_io_period2", c4 - c3, 8);
    iorq_n = 1'b1;
    wait_cen(10, c5, n);
    chk("t6_back_period", c5 - c4, 2);
    chk("t6_back_cur", int'(turbo_cur), 2);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
